// File: rtl/swxbar_pkg.sv
// Shared widths, arbiter state type and flit slice helpers for the swxbar crossbar.
package swxbar_pkg;

    function automatic int width_of(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Low bit of element idx in a flat vector of w-bit elements.
    function automatic int slice_lo(input int idx, input int w);
        return idx * w;
    endfunction

    typedef enum logic {
        ARB_IDLE,
        ARB_LOCKED
    } arb_state_t;

endpackage

// File: rtl/swxbar_if.sv
// Input/output channel bundle of the swxbar switch; master drives flits and out_rdy.
interface swxbar_if #(
    parameter int NPORT = 5,
    parameter int DATAW = 64,
    parameter int NVCH  = 2
);
    import swxbar_pkg::*;

    localparam int VCHW  = width_of(NVCH);
    localparam int PORTW = width_of(NPORT);

    logic [NPORT*DATAW-1:0] in_data;
    logic [NPORT*VCHW-1:0]  in_vch;
    logic [NPORT*PORTW-1:0] in_port;
    logic [NPORT-1:0]       in_req;
    logic [NPORT-1:0]       in_tail;
    logic [NPORT*NPORT-1:0] grt;
    logic [NPORT-1:0]       out_rdy;
    logic [NPORT*DATAW-1:0] out_data;
    logic [NPORT*VCHW-1:0]  out_vch;
    logic [NPORT-1:0]       out_valid;

    modport master (
        output in_data, in_vch, in_port, in_req, in_tail, out_rdy,
        input  grt, out_data, out_vch, out_valid
    );

    modport slave (
        input  in_data, in_vch, in_port, in_req, in_tail, out_rdy,
        output grt, out_data, out_vch, out_valid
    );

endinterface

// File: rtl/swxbar_rrarb.sv
// Per-output round-robin arbiter with packet lock; grant is one-hot and combinational.
module swxbar_rrarb
    import swxbar_pkg::*;
#(
    parameter int NPORT = 5
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic [NPORT-1:0] cand,
    input  logic [NPORT-1:0] tail,
    input  logic             rdy,
    output logic [NPORT-1:0] gnt
);
    localparam int PORTW = width_of(NPORT);

    arb_state_t       state_q, state_d;
    logic [PORTW-1:0] ptr_q, ptr_d;
    logic [PORTW-1:0] owner_q, owner_d;
    logic [PORTW:0]   scan;
    logic [PORTW-1:0] win;
    logic             found;

    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) begin
            state_q <= ARB_IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        gnt     = '0;
        scan    = '0;
        win     = '0;
        found   = 1'b0;
        if (rdy) begin
            if (state_q == ARB_IDLE) begin
                // Scan ptr, ptr+1, ... wrapping at NPORT; first candidate wins.
                for (int j = 0; j < NPORT; j++) begin
                    scan = {1'b0, ptr_q} + (PORTW+1)'(j);
                    if (scan >= (PORTW+1)'(NPORT))
                        scan = scan - (PORTW+1)'(NPORT);
                    if (!found && cand[scan[PORTW-1:0]]) begin
                        found = 1'b1;
                        win   = scan[PORTW-1:0];
                    end
                end
                if (found) begin
                    gnt[win] = 1'b1;
                    ptr_d    = (win == PORTW'(NPORT-1)) ? '0 : win + 1'b1;
                    if (!tail[win]) begin
                        state_d = ARB_LOCKED;
                        owner_d = win;
                    end
                end
            end else if (cand[owner_q]) begin
                gnt[owner_q] = 1'b1;
                if (tail[owner_q])
                    state_d = ARB_IDLE;
            end
        end
    end

endmodule

// File: rtl/swxbar.sv
// NPORT x NPORT wormhole crossbar: candidate decode, per-output arbiters, output mux.
// SWXBAR_OREG_EN adds a one-cycle output register; otherwise outputs are combinational.
module swxbar
    import swxbar_pkg::*;
#(
    parameter int NPORT = 5,
    parameter int DATAW = 64,
    parameter int NVCH  = 2
) (
    input  logic     clk,
    input  logic     rst_,
    swxbar_if.slave  sw
);
    localparam int VCHW  = width_of(NVCH);
    localparam int PORTW = width_of(NPORT);

    for (genvar o = 0; o < NPORT; o++) begin : g_out
        logic [NPORT-1:0] cand;
        logic [NPORT-1:0] gnt;
        logic [DATAW-1:0] d_mux;
        logic [VCHW-1:0]  v_mux;

        // Destinations >= NPORT never equal any o, so they are silently dropped.
        always_comb begin
            cand = '0;
            for (int i = 0; i < NPORT; i++)
                cand[i] = sw.in_req[i] &&
                          (sw.in_port[slice_lo(i, PORTW) +: PORTW] == PORTW'(o));
        end

        swxbar_rrarb #(.NPORT(NPORT)) u_arb (
            .clk  (clk),
            .rst_ (rst_),
            .cand (cand),
            .tail (sw.in_tail),
            .rdy  (sw.out_rdy[o]),
            .gnt  (gnt)
        );

        always_comb begin
            d_mux = '0;
            v_mux = '0;
            for (int i = 0; i < NPORT; i++) begin
                if (gnt[i]) begin
                    d_mux = d_mux | sw.in_data[slice_lo(i, DATAW) +: DATAW];
                    v_mux = v_mux | sw.in_vch[slice_lo(i, VCHW) +: VCHW];
                end
            end
        end

`ifdef SWXBAR_OREG_EN
        logic [DATAW-1:0] d_q;
        logic [VCHW-1:0]  v_q;
        logic             val_q;

        always_ff @(posedge clk or posedge rst_) begin
            if (rst_) begin
                d_q   <= '0;
                v_q   <= '0;
                val_q <= 1'b0;
            end else begin
                d_q   <= d_mux;
                v_q   <= v_mux;
                val_q <= |gnt;
            end
        end

        assign sw.out_data[o*DATAW +: DATAW] = d_q;
        assign sw.out_vch[o*VCHW +: VCHW]    = v_q;
        assign sw.out_valid[o]               = val_q;
`else
        assign sw.out_data[o*DATAW +: DATAW] = d_mux;
        assign sw.out_vch[o*VCHW +: VCHW]    = v_mux;
        assign sw.out_valid[o]               = |gnt;
`endif

        for (genvar i = 0; i < NPORT; i++) begin : g_grt
            assign sw.grt[i*NPORT + o] = gnt[i];
        end
    end

endmodule

// File: tb/tb_swxbar.sv
// Directed and random checks of swxbar against a per-output arbitration model.
module tb_swxbar;
    localparam int NP = 5;
    localparam int DW = 64;
    localparam int NV = 2;
    localparam int PW = 3;

    logic clk = 1'b0;
    logic rst_;
    always #5 clk = ~clk;

    swxbar_if #(.NPORT(NP), .DATAW(DW), .NVCH(NV)) bus();

    swxbar #(.NPORT(NP), .DATAW(DW), .NVCH(NV)) dut (
        .clk  (clk),
        .rst_ (rst_),
        .sw   (bus)
    );

    bit          req [NP];
    bit          tail[NP];
    int          port[NP];
    logic [63:0] data[NP];
    bit          vch [NP];
    bit          rdy [NP];

    int m_ptr[NP];
    bit m_lock[NP];
    int m_own[NP];
    int e_gnt[NP];

    logic [NP*NP-1:0] exp_grt, last_grt;
    logic [NP*DW-1:0] exp_data, last_data;
    logic [NP-1:0]    exp_vch, exp_valid, last_valid;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [NP*DW-1:0] obs, input logic [NP*DW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < NP; i++) begin
            req[i] = 0; tail[i] = 0; port[i] = 0; data[i] = '0; vch[i] = 0; rdy[i] = 1;
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NP; i++) begin
            bus.in_req[i]            = req[i];
            bus.in_tail[i]           = tail[i];
            bus.in_port[i*PW +: PW]  = PW'(port[i]);
            bus.in_data[i*DW +: DW]  = data[i];
            bus.in_vch[i]            = vch[i];
            bus.out_rdy[i]           = rdy[i];
        end
    endtask

    task automatic model_reset();
        for (int o = 0; o < NP; o++) begin
            m_ptr[o] = 0; m_lock[o] = 0; m_own[o] = 0;
        end
    endtask

    // Who wins each output this cycle, straight from the arbitration rules.
    task automatic model_grant();
        exp_grt = '0; exp_data = '0; exp_vch = '0; exp_valid = '0;
        for (int o = 0; o < NP; o++) begin
            int e = -1;
            if (rdy[o]) begin
                if (m_lock[o]) begin
                    if (req[m_own[o]] && port[m_own[o]] == o) e = m_own[o];
                end else begin
                    for (int j = 0; j < NP; j++) begin
                        int i = (m_ptr[o] + j) % NP;
                        if (e < 0 && req[i] && port[i] == o) e = i;
                    end
                end
            end
            e_gnt[o] = e;
            if (e >= 0) begin
                exp_grt[e*NP + o]       = 1'b1;
                exp_data[o*DW +: DW]    = data[e];
                exp_vch[o]              = vch[e];
                exp_valid[o]            = 1'b1;
            end
        end
    endtask

    task automatic model_update();
        for (int o = 0; o < NP; o++) begin
            int e = e_gnt[o];
            if (e >= 0) begin
                if (!m_lock[o]) begin
                    m_ptr[o] = (e + 1) % NP;
                    if (!tail[e]) begin
                        m_lock[o] = 1; m_own[o] = e;
                    end
                end else if (tail[e]) begin
                    m_lock[o] = 0;
                end
            end
        end
    endtask

    // Called just after a falling edge; returns on the next falling edge.
    task automatic step();
        drive();
        #1;
        model_grant();
        last_grt = bus.grt;
        check("grt", bus.grt, exp_grt);
`ifndef SWXBAR_OREG_EN
        last_valid = bus.out_valid;
        last_data  = bus.out_data;
        check("out_valid", bus.out_valid, exp_valid);
        check("out_data", bus.out_data, exp_data);
        check("out_vch", bus.out_vch, exp_vch);
`endif
        @(posedge clk);
        model_update();
`ifdef SWXBAR_OREG_EN
        #1;
        last_valid = bus.out_valid;
        last_data  = bus.out_data;
        check("out_valid", bus.out_valid, exp_valid);
        check("out_data", bus.out_data, exp_data);
        check("out_vch", bus.out_vch, exp_vch);
`endif
        @(negedge clk);
    endtask

    function automatic int winner(input int o);
        int w = -1;
        for (int i = 0; i < NP; i++)
            if (last_grt[i*NP + o]) w = i;
        return w;
    endfunction

    initial begin
        int order[6] = '{0, 1, 3, 0, 1, 3};

        rst_ = 1'b1;
        clear_inputs();
        drive();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", bus.out_valid, 0);
        check("rst_data", bus.out_data, 0);
        check("rst_vch", bus.out_vch, 0);
        check("rst_grt", bus.grt, 0);
        @(negedge clk);
        rst_ = 1'b0;

        // Single-flit packet, then the port must still be free for anyone
        req[2] = 1; port[2] = 4; tail[2] = 1; data[2] = 64'hA5;
        step();
        check("single_grt", last_grt[2*NP + 4], 1);
        check("single_valid", last_valid[4], 1);
        check("single_data", last_data[4*DW +: DW], 64'hA5);
        clear_inputs();
        req[0] = 1; port[0] = 4; tail[0] = 1; data[0] = 64'h77;
        step();
        check("single_idle", winner(4), 0);

        clear_inputs();
        for (int i = 0; i < NP; i++) begin
            port[i] = 2; tail[i] = 1; data[i] = 64'(i + 32'h100);
        end
        req[0] = 1; req[1] = 1; req[3] = 1;
        for (int k = 0; k < 6; k++) begin
            step();
            check("rr_order", winner(2), order[k]);
        end

        clear_inputs();
        req[1] = 1; port[1] = 0;
        req[4] = 1; port[4] = 0; tail[4] = 1; data[4] = 64'h44;
        for (int f = 0; f < 3; f++) begin
            tail[1] = (f == 2); data[1] = 64'(32'h10 + f);
            step();
            check("worm_owner", winner(0), 1);
        end
        req[1] = 0;
        step();
        check("worm_next", winner(0), 4);

        clear_inputs();
        req[0] = 1; port[0] = 3; data[0] = 64'hB0;
        req[2] = 1; port[2] = 3; tail[2] = 1; data[2] = 64'hB2;
        step();
        check("bp_head", winner(3), 0);
        rdy[3] = 0; data[0] = 64'hB1;
        repeat (4) begin
            step();
            check("bp_grt", winner(3), -1);
            check("bp_valid", last_valid[3], 0);
        end
        rdy[3] = 1; tail[0] = 1;
        step();
        check("bp_resume", winner(3), 0);
        req[0] = 0;
        step();
        check("bp_after", winner(3), 2);

        clear_inputs();
        req[3] = 1; port[3] = 1; data[3] = 64'hC3;
        step();
        clear_inputs();
        drive();
        #2;
        rst_ = 1'b1;
        #1;
        check("rst_mid_valid", bus.out_valid, 0);
        @(negedge clk);
        rst_ = 1'b0;
        model_reset();
        req[0] = 1; port[0] = 1; tail[0] = 1; data[0] = 64'hD0;
        req[3] = 1; port[3] = 1; data[3] = 64'hC4;
        step();
        check("rst_new_owner", winner(1), 0);
        clear_inputs();
        req[3] = 1; port[3] = 1; tail[3] = 1;
        step();

        clear_inputs();
        req[4] = 1; port[4] = 6; tail[4] = 1; data[4] = 64'hEE;
        req[0] = 1; port[0] = 2; tail[0] = 1; data[0] = 64'hE0;
        repeat (3) begin
            step();
            check("illegal_none", last_grt[4*NP +: NP], 0);
            check("illegal_other", winner(2), 0);
        end

        repeat (400) begin
            for (int i = 0; i < NP; i++) begin
                req[i]  = ($urandom_range(0, 3) != 0);
                port[i] = int'($urandom_range(0, 6));
                tail[i] = ($urandom_range(0, 2) == 0);
                data[i] = {$urandom, $urandom};
                vch[i]  = $urandom_range(0, 1) != 0;
                rdy[i]  = ($urandom_range(0, 3) != 0);
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
